// File: rtl/foc_pkg.sv
// Shared constants and types for the Clarke scheduler.
// The tag type is sized for the largest supported channel count.
package foc_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int CLARKE_LAT = 4;
  localparam int ISSUE_GAP  = 2;
  localparam int MAX_CH     = 8;
  localparam int TAG_W      = $clog2(MAX_CH);

  typedef logic [TAG_W-1:0] tag_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/clarke_tag_fifo.sv
// Synchronous FIFO of channel tags with flush.
// Pointers carry one wrap bit to tell full from empty.
module clarke_tag_fifo
  import foc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  tag_t din,
  output tag_t dout,
  output logic full,
  output logic empty
);

  localparam int AW = ptr_w(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  tag_t        mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush)
      mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/foc_clarke_sched.sv
// Round-robin scheduler sharing one Clarke pipeline across channels.
// Optional watchdog: CLARKE_SCHED_TIMEOUT_EN adds err_timeout.
module foc_clarke_sched
  import foc_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int TAG_DEPTH = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH*DATA_W-1:0] req_a,
  input  logic [NUM_CH*DATA_W-1:0] req_b,
  output logic [NUM_CH-1:0]        req_ready,
  output logic                     clarke_i_en,
  output logic [DATA_W-1:0]        clarke_a,
  output logic [DATA_W-1:0]        clarke_b,
  input  logic                     clarke_o_en,
  input  logic [DATA_W-1:0]        clarke_alpha,
  input  logic [DATA_W-1:0]        clarke_beta,
  output logic [NUM_CH-1:0]        rsp_valid,
  output logic [DATA_W-1:0]        rsp_alpha,
  output logic [DATA_W-1:0]        rsp_beta,
  output logic                     err_orphan
`ifdef CLARKE_SCHED_TIMEOUT_EN
  ,
  output logic                     err_timeout
`endif
);

  logic [1:0] slot_cnt;
  logic       slot_free;
  logic       fifo_full;
  logic       fifo_empty;
  logic       grant;
  logic       pop;
  logic       flush;
  logic       block;
  tag_t       rr_ptr;
  tag_t       gidx;
  tag_t       head;
  int         idx;
  logic       found;

  // First valid channel at or after the round-robin pointer
  always_comb begin
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_CH;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gidx  = tag_t'(idx);
      end
    end
  end

  assign slot_free = (slot_cnt == 2'd0);
  assign grant     = slot_free & ~fifo_full & found & ~block;
  assign req_ready = grant ? (NUM_CH'(1) << gidx) : '0;
  assign pop       = clarke_o_en & ~fifo_empty;

  clarke_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (grant),
    .pop   (pop),
    .flush (flush),
    .din   (gidx),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef CLARKE_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] to_cnt;
  logic          to_hit;

  assign to_hit = ~fifo_empty & ~clarke_o_en &
                  (to_cnt == TW'(TIMEOUT - 1));
  assign flush  = to_hit;
  assign block  = to_hit;

  // Age of the head tag; restarts whenever the head changes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt      <= '0;
      err_timeout <= 1'b0;
    end else if (fifo_empty || clarke_o_en || to_hit) begin
      to_cnt      <= '0;
      if (to_hit) err_timeout <= 1'b1;
    end else begin
      to_cnt      <= to_cnt + TW'(1);
    end
  end
`else
  logic unused_cfg;

  assign flush      = 1'b0;
  assign block      = 1'b0;
  assign unused_cfg = (TIMEOUT > 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= '0;
      slot_cnt <= '0;
    end else if (grant) begin
      rr_ptr   <= (gidx == tag_t'(NUM_CH - 1)) ?
                  '0 : gidx + tag_t'(1);
      slot_cnt <= 2'(ISSUE_GAP - 1);
    end else if (!slot_free) begin
      slot_cnt <= slot_cnt - 2'd1;
    end
  end

  // Samples stay put between issues
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clarke_i_en <= 1'b0;
      clarke_a    <= '0;
      clarke_b    <= '0;
    end else begin
      clarke_i_en <= grant;
      if (grant) begin
        clarke_a <= req_a[gidx*DATA_W +: DATA_W];
        clarke_b <= req_b[gidx*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid  <= '0;
      rsp_alpha  <= '0;
      rsp_beta   <= '0;
      err_orphan <= 1'b0;
    end else begin
      rsp_valid <= pop ? (NUM_CH'(1) << head) : '0;
      if (pop) begin
        rsp_alpha <= clarke_alpha;
        rsp_beta  <= clarke_beta;
      end
      if (clarke_o_en && fifo_empty)
        err_orphan <= 1'b1;
    end
  end

endmodule
